div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
//  One quotient bit per clock; EX stalls on busy_o.
//  On completion presents {remainder, quotient} on result_o, which EX forwards
//  through MEM/WB as the HI/LO write data (hi = result_o[63:32], lo = result_o[31:0]).
// PARAMETERS
//  WIDTH  32  operand width; result_o is 2*WIDTH; iteration counter is clog2(WIDTH)+1 bits
// PORTS
//  clk         in   1        clock; all state updates on posedge
//  rst         in   1        synchronous reset, active-high; priority over all inputs
//  start_i     in   1        request division; EX holds it high until ready_o is seen
//  annul_i     in   1        cancel in-flight op (branch/exception flush)
//  signed_i    in   1        1 = DIV (two's complement), 0 = DIVU
//  dividend_i  in   WIDTH    rs operand
//  divisor_i   in   WIDTH    rt operand
//  busy_o      out  1        high in RUN and DIVZERO; EX stall request
//  ready_o     out  1        registered; high only in DONE
//  result_o    out  2*WIDTH  {remainder, quotient}; valid while ready_o=1, else 0
// BEHAVIOUR
//  Reset: state=IDLE; busy_o=0; ready_o=0; result_o=0; counter and datapath regs cleared.
//  States:
//   IDLE:
//    - if start_i && !annul_i: latch operands.
//    - signed_i=1: latch |dividend|, |divisor| and the two sign bits; |x| taken as
//      WIDTH-bit unsigned, so 0x80000000 -> 0x80000000.
//    - divisor_i==0 -> DIVZERO; else -> RUN with cnt=0.
//    - start_i && annul_i in IDLE: ignored, stay IDLE.
//   RUN:
//    - per edge: {rem,quo} <<= 1 with the next dividend bit entering rem;
//      if rem >= divisor then rem -= divisor and quo[0]=1.
//    - compare and subtract are WIDTH+1 bits wide, no truncation.
//    - the edge performing iteration 32 (cnt==WIDTH-1) goes to DONE and loads
//      result_o/ready_o.
//    - annul_i=1 -> IDLE at next edge; result_o stays 0, ready_o never asserts.
//   DIVZERO:
//    - -> DONE next edge with result_o=0 (HI/LO defined as 0 for /0; no exception).
//    - annul_i -> IDLE instead.
//   DONE:
//    - ready_o=1; result_o held stable.
//    - leave to IDLE on the first edge with start_i=0; ready_o and result_o
//      clear on that edge.
//    - annul_i ignored here (result already committed by EX).
//    - start_i held high keeps DONE: a back-to-back divide needs start_i low for
//      >=1 cycle.
//  Latency: start_i sampled at edge E0.
//   - normal: ready_o visible after E32 (32 cycles).
//   - divide-by-zero: ready_o visible after E1.
//  Sign fix-up, applied when entering DONE, signed_i=1 only:
//   - quotient negated iff sign(dividend)^sign(divisor).
//   - remainder negated iff sign(dividend); remainder sign follows dividend.
//  Overflow: 0x80000000 / 0xFFFFFFFF signed -> quo=0x80000000, rem=0 (wraps, no trap).
//  Operand inputs are sampled only in IDLE; changes during RUN have no effect.
//  rst asserted mid-operation -> IDLE next edge, all outputs 0.
// TESTING
//  1 DIVU 100/7: start at E0 -> busy_o 1 for 32 cycles, ready_o after E32,
//    result_o=0x00000002_0000000E; drop start_i -> ready_o 0, result_o 0 next edge.
//  2 DIV -7/2 (0xFFFFFFF9/0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD;
//    DIV 7/-2 -> 0x00000001_FFFFFFFD.
//  3 DIV 0x80000000/0xFFFFFFFF -> 0x00000000_80000000;
//    DIVU 0xFFFFFFFF/1 -> 0x00000000_FFFFFFFF.
//  4 divisor 0 (both signedness) -> ready_o after E1, result_o=0, busy_o high 1 cycle.
//  5 annul_i pulse at iteration 10 -> IDLE next edge, no ready_o;
//    new DIVU 9/3 then completes with 0x00000000_00000003.
//  6 rst at iteration 20, then start held high -> outputs 0 after reset edge;
//    op restarts cleanly, full 32-cycle latency.

Source files
------------

// File: rtl/div_unit_if.sv
// Divider request/response bundle between the EX stage and div_unit.
interface div_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic                 start_i;
  logic                 annul_i;
  logic                 signed_i;
  logic [WIDTH-1:0]     dividend_i;
  logic [WIDTH-1:0]     divisor_i;
  logic                 busy_o;
  logic                 ready_o;
  logic [2*WIDTH-1:0]   result_o;

  // EX stage side: issues the request, watches stall/ready/result.
  modport master (
    output start_i, annul_i, signed_i, dividend_i, divisor_i,
    input  busy_o, ready_o, result_o
  );

  // Divider side.
  modport slave (
    input  start_i, annul_i, signed_i, dividend_i, divisor_i,
    output busy_o, ready_o, result_o
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per clock,
// result presented as {remainder, quotient} for the HI/LO write.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  div_unit_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned RW    = WIDTH + 1;
  localparam int unsigned RES_W = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DIVZERO, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]      rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic [RES_W-1:0]   result_q, result_d;

  logic [RW-1:0]      rem_sh;
  logic [RW-1:0]      diff;
  logic               ge;
  logic [RW-1:0]      rem_nx;
  logic [WIDTH-1:0]   quo_nx;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   quo_fix;

  // State and datapath registers; reset has priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dsr_q     <= dsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
    end
  end

  // Next-state, iteration datapath and registered-output values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    busy_d    = 1'b0;
    ready_d   = ready_q;
    result_d  = result_q;

    // Partial remainder never exceeds 2*divisor-1, so WIDTH+1 bits suffice.
    rem_sh  = RW'({rem_q, quo_q[WIDTH-1]});
    diff    = rem_sh - {1'b0, dsr_q};
    ge      = (rem_sh >= {1'b0, dsr_q});
    rem_nx  = ge ? diff : rem_sh;
    quo_nx  = {quo_q[WIDTH-2:0], ge};
    rem_fix = neg_rem_q ? (WIDTH'(0) - rem_nx[WIDTH-1:0]) : rem_nx[WIDTH-1:0];
    quo_fix = neg_quo_q ? (WIDTH'(0) - quo_nx) : quo_nx;

    // Magnitudes as WIDTH-bit unsigned: the most negative value maps to itself.
    a_abs = (bus.signed_i && bus.dividend_i[WIDTH-1]) ? (WIDTH'(0) - bus.dividend_i)
                                                      : bus.dividend_i;
    b_abs = (bus.signed_i && bus.divisor_i[WIDTH-1])  ? (WIDTH'(0) - bus.divisor_i)
                                                      : bus.divisor_i;

    case (state_q)
      IDLE: begin
        if (bus.start_i && !bus.annul_i) begin
          quo_d     = a_abs;
          dsr_d     = b_abs;
          rem_d     = '0;
          cnt_d     = '0;
          neg_quo_d = bus.signed_i & (bus.dividend_i[WIDTH-1] ^ bus.divisor_i[WIDTH-1]);
          neg_rem_d = bus.signed_i & bus.dividend_i[WIDTH-1];
          state_d   = (bus.divisor_i == '0) ? DIVZERO : RUN;
          busy_d    = 1'b1;
        end
      end
      RUN: begin
        if (bus.annul_i) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d  = DONE;
            ready_d  = 1'b1;
            result_d = {rem_fix, quo_fix};
          end else begin
            busy_d = 1'b1;
          end
        end
      end
      DIVZERO: begin
        if (bus.annul_i) begin
          state_d = IDLE;
        end else begin
          state_d  = DONE;
          ready_d  = 1'b1;
          result_d = '0;
        end
      end
      DONE: begin
        // Held start keeps the result; EX must drop start before a new divide.
        if (!bus.start_i) begin
          state_d  = IDLE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy_o   = busy_q;
  assign bus.ready_o  = ready_q;
  assign bus.result_o = result_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed fix-up, /0, annul and reset.
module tb_div_unit;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},   64'(bus.busy_o),  64'd0);
    check({tag, "_ready"},  64'(bus.ready_o), 64'd0);
    check({tag, "_result"}, bus.result_o,     64'd0);
  endtask

  // Full divide: start at E0, check latency, hold start one extra cycle, release.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
    bus.signed_i   = sgn;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    bus.annul_i    = 1'b0;
    bus.start_i    = 1'b1;
    tick();
    check({tag, "_busy_e0"},  64'(bus.busy_o),  64'd1);
    check({tag, "_ready_e0"}, 64'(bus.ready_o), 64'd0);
    // Operands are only sampled in IDLE; scramble them mid-operation.
    bus.dividend_i = $urandom;
    bus.divisor_i  = $urandom;
    bus.signed_i   = ~sgn;
    if (b == 32'd0) begin
      tick();
    end else begin
      repeat (31) tick();
      check({tag, "_busy_e31"},   64'(bus.busy_o),  64'd1);
      check({tag, "_ready_e31"},  64'(bus.ready_o), 64'd0);
      check({tag, "_result_e31"}, bus.result_o,     64'd0);
      tick();
    end
    check({tag, "_ready"},  64'(bus.ready_o), 64'd1);
    check({tag, "_busy"},   64'(bus.busy_o),  64'd0);
    check({tag, "_result"}, bus.result_o,     exp);
    bus.annul_i = 1'b1;
    tick();
    check({tag, "_hold_ready"},  64'(bus.ready_o), 64'd1);
    check({tag, "_hold_result"}, bus.result_o,     exp);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    tick();
    check_idle({tag, "_release"});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst            = 1'b1;
    bus.start_i    = 1'b0;
    bus.annul_i    = 1'b0;
    bus.signed_i   = 1'b0;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    tick();
    tick();
    check_idle("reset");
    rst = 1'b0;
    tick();

    run_div("divu_100_7",   1'b0, 32'd100,        32'd7,        64'h00000002_0000000E);
    run_div("div_m7_2",     1'b1, 32'hFFFFFFF9,   32'h00000002, 64'hFFFFFFFF_FFFFFFFD);
    run_div("div_7_m2",     1'b1, 32'h00000007,   32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
    run_div("div_ovf",      1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000);
    run_div("divu_max_1",   1'b0, 32'hFFFFFFFF,   32'h00000001, 64'h00000000_FFFFFFFF);
    run_div("divu_big",     1'b0, 32'hFFFFFFFF,   32'h80000000, 64'h7FFFFFFF_00000001);
    run_div("divu_zero",    1'b0, 32'd1234,       32'd0,        64'd0);
    run_div("div_zero",     1'b1, 32'hFFFFFF00,   32'd0,        64'd0);

    // start with annul in IDLE is ignored
    bus.dividend_i = 32'd50;
    bus.divisor_i  = 32'd5;
    bus.signed_i   = 1'b0;
    bus.start_i    = 1'b1;
    bus.annul_i    = 1'b1;
    tick();
    check_idle("start_annul_idle");

    // annul at iteration 10
    bus.annul_i = 1'b0;
    tick();
    repeat (10) tick();
    check("annul_pre_busy", 64'(bus.busy_o), 64'd1);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    tick();
    check_idle("annul");
    bus.annul_i = 1'b0;
    repeat (30) tick();
    check_idle("annul_after");
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

    // reset at iteration 20 with start held high
    bus.dividend_i = 32'd1000;
    bus.divisor_i  = 32'd33;
    bus.signed_i   = 1'b0;
    bus.start_i    = 1'b1;
    tick();
    repeat (20) tick();
    rst = 1'b1;
    tick();
    check_idle("rst_mid");
    rst = 1'b0;
    run_div("divu_after_rst", 1'b0, 32'd1000, 32'd33, 64'h0000000A_0000001E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
